// File: rtl/bus_mem_slave.sv
// Byte-wide memory slave behind a four-phase req/ack handshake, with
// programmable wait states, out-of-range error flag and a transfer counter.
module bus_mem_slave #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 48,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bus_req,
  input  logic              bus_wr,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_ack,
  output logic              bus_err,
  output logic [15:0]       xfer_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

  state_t            state_reg;
  logic [3:0]        wait_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              wr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] mem_reg [DEPTH];

  logic              enter_ack;
  logic              in_range;
  logic [DEPTH-1:0]  we;

  // WAIT always spans WAIT_CYCLES+1 edges so ack rises WAIT_CYCLES+1 edges
  // after the request is sampled, including the zero-wait case.
  always_comb begin
    enter_ack = (state_reg == S_WAIT) && bus_req && (wait_cnt_reg == 4'd0);
    in_range  = int'(addr_reg) < DEPTH;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign we[gi] = enter_ack && wr_reg && in_range && (addr_reg == ADDR_W'(gi));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) mem_reg[i] <= wdata_reg;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      addr_reg     <= '0;
      wr_reg       <= 1'b0;
      wdata_reg    <= '0;
      bus_ack      <= 1'b0;
      bus_err      <= 1'b0;
      bus_rdata    <= '0;
      xfer_cnt     <= 16'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus_req) begin
            addr_reg     <= bus_addr;
            wr_reg       <= bus_wr;
            wdata_reg    <= bus_wdata;
            wait_cnt_reg <= 4'(WAIT_CYCLES);
            state_reg    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus_req) begin
            // Master gave up: no write, no ack, no count.
            wait_cnt_reg <= 4'd0;
            state_reg    <= S_IDLE;
          end else if (enter_ack) begin
            state_reg <= S_ACK;
            bus_ack   <= 1'b1;
            bus_err   <= !in_range;
            xfer_cnt  <= xfer_cnt + 16'd1;
            if (!wr_reg) bus_rdata <= in_range ? mem_reg[addr_reg] : '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        S_ACK: begin
          if (!bus_req) begin
            bus_ack   <= 1'b0;
            bus_err   <= 1'b0;
            state_reg <= S_RELEASE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
